// File: rtl/counter_pkg.sv
// Shared constants and sizing helper for the parametrised up/down counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input longint unsigned value);
        int result;
        result = 0;
        while ((64'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles down to one tick every PRESCALE enabled cycles.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW_RAW = clog2(PRESCALE);
    localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
    localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE    = PW'(1);

    // Down-counter holding the enabled cycles left before the next tick;
    // equivalent to an up-counting phase of PRESCALE-1-remaining_q.
    logic [PW-1:0] remaining_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q <= RELOAD;
        end else if (clr) begin
            remaining_q <= RELOAD;
        end else if (en) begin
            if (remaining_q == '0) begin
                remaining_q <= RELOAD;
            end else begin
                remaining_q <= remaining_q - ONE;
            end
        end
    end

    assign tick = en && !clr && (remaining_q == '0);

endmodule

// File: rtl/updown_counter_param.sv
// Up/down counter with programmable modulus, wrap/saturate mode, parallel load,
// tick prescaler and registered boundary (terminal-count) pulse.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     SATURATE = MODE_WRAP,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be within 2..32");
    end
    if (MAX_VAL < 1 || MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
        $error("updown_counter_param: MAX_VAL must be >= 1 and < 2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("updown_counter_param: PRESCALE must be within 1..65535");
    end

    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

    logic             tick;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    // Boundaries are explicit compares so non-power-of-two moduli wrap correctly.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (tick) begin
            if (up_down == DIR_UP) begin
                if (count_q == MAX_C) begin
                    tc_d    = 1'b1;
                    count_d = SAT_MODE ? MAX_C : '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = SAT_MODE ? '0 : MAX_C;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign at_max  = (count_q == MAX_C);
    assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: four counter configurations share one stimulus stream.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [7:0] cnt   [4];
    logic       tcv   [4];
    logic       amax  [4];
    logic       azero [4];

    int checks   = 0;
    int failures = 0;

    // dut0: mod 10 wrap; dut1: mod 10 saturate; dut2: mod 13 wrap /4; dut3: mod 256 wrap /3
    int c_max [4] = '{9, 9, 12, 255};
    int c_sat [4] = '{0, 1, 0, 0};
    int c_pre [4] = '{1, 1, 4, 3};

    int m_cnt [4];
    int m_ph  [4];
    int m_tc  [4];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(8), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count(cnt[0]), .tc(tcv[0]), .at_max(amax[0]), .at_zero(azero[0]));

    updown_counter_param #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count(cnt[1]), .tc(tcv[1]), .at_max(amax[1]), .at_zero(azero[1]));

    updown_counter_param #(.WIDTH(8), .MAX_VAL(12), .SATURATE(0), .PRESCALE(4)) dut_pre (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count(cnt[2]), .tc(tcv[2]), .at_max(amax[2]), .at_zero(azero[2]));

    updown_counter_param #(.WIDTH(8), .SATURATE(0), .PRESCALE(3)) dut_full (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count(cnt[3]), .tc(tcv[3]), .at_max(amax[3]), .at_zero(azero[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0;
            m_ph[k]  = 0;
            m_tc[k]  = 0;
        end
    endtask

    // Expected state after the coming edge, from the current inputs.
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            m_tc[k] = 0;
            if (load) begin
                m_cnt[k] = (int'(load_val) > c_max[k]) ? c_max[k] : int'(load_val);
                m_ph[k]  = 0;
            end else if (en) begin
                if (m_ph[k] == c_pre[k] - 1) begin
                    m_ph[k] = 0;
                    if (up_down) begin
                        if (m_cnt[k] == c_max[k]) begin
                            m_tc[k]  = 1;
                            m_cnt[k] = (c_sat[k] != 0) ? c_max[k] : 0;
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                        end
                    end else begin
                        if (m_cnt[k] == 0) begin
                            m_tc[k]  = 1;
                            m_cnt[k] = (c_sat[k] != 0) ? 0 : c_max[k];
                        end else begin
                            m_cnt[k] = m_cnt[k] - 1;
                        end
                    end
                end else begin
                    m_ph[k] = m_ph[k] + 1;
                end
            end
        end
    endtask

    // Short reset pulse between clock edges.
    task automatic apply_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        en = 1'b1;
        reset = 1'b1;
        #2;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cnt[k] !== 8'd0) begin
                failures++;
                $display("FAIL reset_count dut%0d got=%0d exp=0", k, cnt[k]);
            end
            checks++;
            if (tcv[k] !== 1'b0 || azero[k] !== 1'b1 || amax[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_flags dut%0d got tc=%b at_zero=%b at_max=%b exp tc=0 at_zero=1 at_max=0",
                         k, tcv[k], azero[k], amax[k]);
            end
        end
        step();
        checks++;
        if (cnt[0] !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold_through_edge got=%0d exp=0", cnt[0]);
        end
        reset = 1'b0;
        en = 1'b0;
        model_reset();
    endtask

    task automatic test_wrap_up();
        int exp_c;
        apply_reset();
        en = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_c = (i + 1) % 10;
            checks++;
            if (cnt[0] !== 8'(exp_c)) begin
                failures++;
                $display("FAIL wrap_up_count cycle=%0d got=%0d exp=%0d", i, cnt[0], exp_c);
            end
            checks++;
            if (tcv[0] !== (i == 9)) begin
                failures++;
                $display("FAIL wrap_up_tc cycle=%0d got=%b exp=%b", i, tcv[0], (i == 9));
            end
            checks++;
            if (amax[0] !== (exp_c == 9)) begin
                failures++;
                $display("FAIL wrap_up_at_max cycle=%0d got=%b exp=%b", i, amax[0], (exp_c == 9));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        apply_reset();
        up_down = 1'b0;
        en = 1'b1;
        checks++;
        if (azero[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_down_at_zero_start got=%b exp=1", azero[0]);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cnt[0] !== 8'(9 - i)) begin
                failures++;
                $display("FAIL wrap_down_count cycle=%0d got=%0d exp=%0d", i, cnt[0], 9 - i);
            end
            checks++;
            if (tcv[0] !== (i == 0) || azero[0] !== 1'b0) begin
                failures++;
                $display("FAIL wrap_down_flags cycle=%0d got tc=%b at_zero=%b exp tc=%b at_zero=0",
                         i, tcv[0], azero[0], (i == 0));
            end
        end
        en = 1'b0;
        up_down = 1'b1;
    endtask

    task automatic test_saturate();
        apply_reset();
        load_val = 8'd8;
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (cnt[1] !== 8'd8 || tcv[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_load got=%0d tc=%b exp=8 tc=0", cnt[1], tcv[1]);
        end
        en = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (cnt[1] !== 8'd9 || amax[1] !== 1'b1) begin
                failures++;
                $display("FAIL sat_up_count cycle=%0d got=%0d at_max=%b exp=9 at_max=1", i, cnt[1], amax[1]);
            end
            checks++;
            if (tcv[1] !== (i > 0)) begin
                failures++;
                $display("FAIL sat_up_tc cycle=%0d got=%b exp=%b", i, tcv[1], (i > 0));
            end
        end
        up_down = 1'b0;
        step();
        checks++;
        if (cnt[1] !== 8'd8 || tcv[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_down_step got=%0d tc=%b exp=8 tc=0", cnt[1], tcv[1]);
        end
        en = 1'b0;
        up_down = 1'b1;
    endtask

    task automatic test_load();
        int exp_c;
        apply_reset();
        load_val = 8'd200;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_c = (200 > c_max[k]) ? c_max[k] : 200;
            checks++;
            if (cnt[k] !== 8'(exp_c)) begin
                failures++;
                $display("FAIL load_clamp dut%0d got=%0d exp=%0d", k, cnt[k], exp_c);
            end
        end
        apply_reset();
        en = 1'b1;
        up_down = 1'b1;
        repeat (5) step();
        checks++;
        if (cnt[0] !== 8'd5) begin
            failures++;
            $display("FAIL load_precount got=%0d exp=5", cnt[0]);
        end
        load_val = 8'd3;
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (cnt[0] !== 8'd3 || tcv[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_over_enable got=%0d tc=%b exp=3 tc=0", cnt[0], tcv[0]);
        end
        step();
        checks++;
        if (cnt[0] !== 8'd4) begin
            failures++;
            $display("FAIL load_resume got=%0d exp=4", cnt[0]);
        end
        en = 1'b0;
    endtask

    task automatic test_prescale();
        apply_reset();
        en = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (cnt[2] !== ((i >= 4) ? 8'd1 : 8'd0)) begin
                failures++;
                $display("FAIL prescale_run cycle=%0d got=%0d exp=%0d", i, cnt[2], (i >= 4) ? 1 : 0);
            end
        end
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        step();
        checks++;
        if (cnt[2] !== 8'd1) begin
            failures++;
            $display("FAIL prescale_frozen_phase got=%0d exp=1", cnt[2]);
        end
        step();
        checks++;
        if (cnt[2] !== 8'd2) begin
            failures++;
            $display("FAIL prescale_resume got=%0d exp=2", cnt[2]);
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1;
        up_down = 1'b1;
        repeat (30) step();
        checks++;
        if (cnt[2] !== 8'd7 || tcv[0] !== 1'b1) begin
            failures++;
            $display("FAIL async_prereset got dut2=%0d dut0_tc=%b exp dut2=7 dut0_tc=1", cnt[2], tcv[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (cnt[2] !== 8'd0 || azero[2] !== 1'b1) begin
            failures++;
            $display("FAIL async_clear_count got=%0d at_zero=%b exp=0 at_zero=1", cnt[2], azero[2]);
        end
        checks++;
        if (tcv[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_clear_tc got=%b exp=0", tcv[0]);
        end
        step();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (cnt[2] !== ((i == 4) ? 8'd1 : 8'd0)) begin
                failures++;
                $display("FAIL async_first_step cycle=%0d got=%0d exp=%0d", i, cnt[2], (i == 4) ? 1 : 0);
            end
        end
        en = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            en = ($urandom_range(9) < 8);
            if ($urandom_range(7) == 0) up_down = ~up_down;
            load = ($urandom_range(24) == 0);
            load_val = ($urandom_range(1) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
            if ($urandom_range(120) == 0) begin
                #1;
                reset = 1'b1;
                #1;
                reset = 1'b0;
                model_reset();
            end
            model_edge();
            step();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cnt[k] !== 8'(m_cnt[k])) begin
                    failures++;
                    $display("FAIL rand_count n=%0d dut%0d got=%0d exp=%0d", n, k, cnt[k], m_cnt[k]);
                end
                checks++;
                if (tcv[k] !== 1'(m_tc[k])) begin
                    failures++;
                    $display("FAIL rand_tc n=%0d dut%0d got=%b exp=%0d", n, k, tcv[k], m_tc[k]);
                end
                checks++;
                if (amax[k] !== (m_cnt[k] == c_max[k]) || azero[k] !== (m_cnt[k] == 0)) begin
                    failures++;
                    $display("FAIL rand_flags n=%0d dut%0d got at_max=%b at_zero=%b exp at_max=%b at_zero=%b",
                             n, k, amax[k], azero[k], (m_cnt[k] == c_max[k]), (m_cnt[k] == 0));
                end
            end
        end
        en = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_prescale();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter, successor to the fixed 8-bit up/down counter. Adds programmable modulus, wrap or saturate mode, and count enable. Also adds synchronous parallel load, a built-in tick prescaler, and terminal-count/boundary flags. Used as a generic event/timebase counter feeding control FSMs and display logic in the same clock domain.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MAX_VAL, 2**WIDTH-1, highest count value (modulus-1); must be >= 1 and < 2**WIDTH
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries
PRESCALE, 1, count step occurs once every PRESCALE enabled cycles (1..65535)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; prescaler advances only while high
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle pulse on boundary step
at_max  output  1  count == MAX_VAL (combinational from count)
at_zero  output  1  count == 0 (combinational from count)

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): count=0, tc=0, prescaler phase=0; at_zero=1, at_max=0.
- tick = en && (prescaler phase == PRESCALE-1). The prescaler phase increments while en=1 and wraps to 0 on tick. It holds while en=0. With PRESCALE=1, tick=en.
- Priority per cycle: reset > load > tick > hold.
- Load: count <= min(load_val, MAX_VAL) on the next edge. Prescaler phase <= 0, tc <= 0. en and up_down are ignored that cycle.
- Tick, up_down=1:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: wrap mode -> 0; saturate mode -> hold MAX_VAL.
- Tick, up_down=0:
  - count>0: count-1.
  - count==0: wrap mode -> MAX_VAL; saturate mode -> hold 0.
- tc: registered. It is 1 for exactly the cycle after a tick that occurred at the boundary in the direction of travel (up at MAX_VAL, or down at 0), in both modes. Otherwise 0. In saturate mode, repeated ticks at the boundary give tc=1 each tick.
- Latency: count and tc update on the clock edge following the qualifying input cycle. at_max/at_zero follow count with zero added latency.
- up_down may change on any cycle. The new direction applies to the next tick; no pipeline state is kept.
- Arithmetic is in WIDTH bits. Wrap never relies on natural 2**WIDTH overflow, so a non-power-of-two MAX_VAL works. Load values above MAX_VAL are clamped, never truncated.
- Reset asserted mid-count or mid-prescale clears all state immediately, without waiting for clk.

Decomposition:
- Shared package counter_pkg:
  - direction constants DIR_UP=1, DIR_DOWN=0.
  - mode constants MODE_WRAP=0, MODE_SAT=1.
  - helper function clog2 for sizing the prescaler phase register.
- One sub-module, tick_prescaler (params PRESCALE; ports clk, reset, en, clr, tick). It is instantiated once, with clr driven by load. The counter core stays in the top.

Test Plan:
1. WIDTH=8, MAX_VAL=9, SATURATE=0, PRESCALE=1: reset, then en=1 up_down=1 for 12 cycles -> count 1..9,0,1,2. tc=1 only in the cycle after count 9->0. at_max=1 while count=9.
2. Same config, count=0, up_down=0, en=1 for 3 cycles -> count 9,8,7. tc pulse once after 0->9. at_zero deasserts after the first edge.
3. SATURATE=1, MAX_VAL=9: load_val=8 load=1, then up for 4 ticks -> 8,9,9,9,9. tc=1 in each of the last 3 cycles. Then down for 1 tick -> 8, tc=0.
4. load_val=200 with MAX_VAL=9 -> count=9. Assert load and en together at count=5 -> load wins, count=load value, no step that cycle.
5. PRESCALE=4, en=1, up -> count increments every 4th cycle. Drop en for 3 cycles mid-phase -> phase frozen, the next step comes exactly at the remaining phase count.
6. Assert reset asynchronously between clock edges at count=7, phase=2 -> count=0, tc=0 immediately. After release, the first step takes PRESCALE enabled cycles.
